// File: rtl/apb_master_fsm_gen.sv
// AHB-to-APB transfer controller: sequences one APB3 access per accepted AHB transfer,
// inserts pready wait states and reports slave errors/timeouts as a two-cycle AHB ERROR.
module apb_master_fsm_gen #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic               valid,
    input  logic               hwrite,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [DATA_W-1:0]  hwdata,
    input  logic [NUM_SLV-1:0] tempselx,
    output logic               hreadyout,
    output logic               hresp,
    output logic [DATA_W-1:0]  hrdata,
    output logic [ADDR_W-1:0]  paddr,
    output logic [DATA_W-1:0]  pwdata,
    output logic               pwrite,
    output logic [NUM_SLV-1:0] pselx,
    output logic               penable,
    input  logic               pready,
    input  logic [DATA_W-1:0]  prdata,
    input  logic               pslverr
);

    // state  | meaning
    // IDLE   | ready for a new AHB transfer
    // WWAIT  | write accepted, capturing hwdata
    // SETUP  | APB setup phase (psel high, penable low)
    // ACCESS | APB access phase, waiting for pready
    // ERR1   | first ERROR cycle (hresp=1, hreadyout=0)
    // ERR2   | second ERROR cycle (hresp=1, hreadyout=1)
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WWAIT  = 3'd1;
    localparam logic [2:0] SETUP  = 3'd2;
    localparam logic [2:0] ACCESS = 3'd3;
    localparam logic [2:0] ERR1   = 3'd4;
    localparam logic [2:0] ERR2   = 3'd5;

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [2:0]         state;
    logic [NUM_SLV-1:0] sel_q;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               accept;
    logic               mapped;
    logic               timeout_hit;

    assign accept      = valid && hreadyout && (state == IDLE);
    // A multi-hot decode is treated like an unmapped address so pselx can never be multi-hot.
    assign mapped      = $onehot(tempselx);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= IDLE;
            sel_q     <= '0;
            tmo_cnt   <= '0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            pselx     <= '0;
            penable   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hreadyout <= 1'b0;
                        if (!mapped) begin
                            hresp <= 1'b1;
                            state <= ERR1;
                        end else begin
                            sel_q  <= tempselx;
                            paddr  <= haddr;
                            pwrite <= hwrite;
                            if (hwrite) begin
                                state <= WWAIT;
                            end else begin
                                pselx <= tempselx;
                                state <= SETUP;
                            end
                        end
                    end
                end
                WWAIT: begin
                    pwdata <= hwdata;
                    pselx  <= sel_q;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready || timeout_hit) begin
                        pselx   <= '0;
                        penable <= 1'b0;
                        tmo_cnt <= '0;
                        if (pready && !pslverr) begin
                            hreadyout <= 1'b1;
                            state     <= IDLE;
                            if (!pwrite) hrdata <= prdata;
                        end else begin
                            hresp <= 1'b1;
                            state <= ERR1;
                        end
                    end else if (TIMEOUT_CYC != 0) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= ERR2;
                end
                ERR2: begin
                    hresp <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    pselx     <= '0;
                    penable   <= 1'b0;
                    tmo_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
